// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_pkg
//  Description : Shared types and helpers for the sipo_stream packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for an argument of 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Low bit offset of word k inside the packed output word.
    function automatic int slot_offset(input int k, input bit lsb_first,
                                       input int n_width, input int m_width);
        return lsb_first ? (m_width * k) : (n_width - m_width * (k + 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_stream.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_stream
//  Description : Serial-in/parallel-out packer with valid/ready on both sides,
//                early termination with zero padding and a registered output.
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_stream
    import sipo_pkg::*;
#(
    parameter int N_WIDTH   = 1344,
    parameter int M_WIDTH   = 64,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     clr,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [M_WIDTH-1:0]                       in_data,
    input  logic                                     in_last,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [N_WIDTH-1:0]                       out_data,
    output logic [clog2(N_WIDTH/M_WIDTH+1)-1:0]      out_count
);

    localparam int c_words = N_WIDTH / M_WIDTH;
    localparam int c_cnt_w = (c_words > 1) ? clog2(c_words) : 1;
    localparam int c_ocw   = clog2(c_words + 1);

    generate
        if ((N_WIDTH % M_WIDTH) != 0 || N_WIDTH < M_WIDTH) begin : g_width_check
            $error("sipo_stream: N_WIDTH must be a positive multiple of M_WIDTH");
        end
    endgenerate

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [N_WIDTH-1:0]   r_buf;
    logic [N_WIDTH-1:0]   r_out_data;
    logic [c_ocw-1:0]     r_out_count;
    logic                 r_out_valid;

    logic [N_WIDTH-1:0]   w_buf_wr;
    logic                 w_in_beat;
    logic                 w_slot_free;
    logic                 w_complete;
    logic [c_ocw-1:0]     w_count;

    assign in_ready    = (r_state == FILL) && !clr;
    assign w_in_beat   = in_valid && in_ready;
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_complete  = (r_cnt == c_cnt_w'(c_words - 1)) || in_last;
    assign w_count     = c_ocw'(r_cnt) + c_ocw'(1);

    // Current buffer with the incoming word placed into slot r_cnt.
    always_comb begin
        w_buf_wr = r_buf;
        for (int k = 0; k < c_words; k++) begin
            if (r_cnt == c_cnt_w'(k)) begin
                w_buf_wr[slot_offset(k, LSB_FIRST, N_WIDTH, M_WIDTH) +: M_WIDTH] = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
        end else if (clr) begin
            r_state     <= FILL;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                FILL: begin
                    if (w_in_beat) begin
                        if (w_complete && w_slot_free) begin
                            r_out_data  <= w_buf_wr;
                            r_out_count <= w_count;
                            r_out_valid <= 1'b1;
                            r_buf       <= '0;
                            r_cnt       <= '0;
                        end else if (w_complete) begin
                            // r_cnt is kept so PEND knows the packet length.
                            r_buf   <= w_buf_wr;
                            r_state <= PEND;
                        end else begin
                            r_buf <= w_buf_wr;
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                PEND: begin
                    if (w_slot_free) begin
                        r_out_data  <= r_buf;
                        r_out_count <= w_count;
                        r_out_valid <= 1'b1;
                        r_buf       <= '0;
                        r_cnt       <= '0;
                        r_state     <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_sipo_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo_stream
//  Description : Scoreboard bench driving an MSB-first and an LSB-first
//                sipo_stream (N=256, M=64) from a shared input stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_stream;

    logic         clk;
    logic         rst_n;
    logic         clr;
    logic         in_valid;
    logic [63:0]  in_data;
    logic         in_last;
    logic         out_ready;

    logic         in_ready0, in_ready1;
    logic         out_valid0, out_valid1;
    logic [255:0] out_data0, out_data1;
    logic [2:0]   out_count0, out_count1;

    int n_vec  = 0;
    int n_miss = 0;
    int stalls = 0;
    int cyc    = 0;

    logic [63:0]  m_words[$];
    logic [255:0] q0[$];
    logic [255:0] q1[$];
    logic [2:0]   qc0[$];
    logic [2:0]   qc1[$];
    int           hs_cyc[$];

    sipo_stream #(.N_WIDTH(256), .M_WIDTH(64), .LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_count(out_count0)
    );

    sipo_stream #(.N_WIDTH(256), .M_WIDTH(64), .LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_count(out_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference packing: word k goes to the top-down or bottom-up slot k.
    task automatic model_accept(input logic [63:0] d, input logic last);
        logic [255:0] e0;
        logic [255:0] e1;
        m_words.push_back(d);
        if (m_words.size() == 4 || last) begin
            e0 = '0;
            e1 = '0;
            foreach (m_words[k]) begin
                e1[64*k +: 64]      = m_words[k];
                e0[255-64*k -: 64]  = m_words[k];
            end
            q0.push_back(e0);
            q1.push_back(e1);
            qc0.push_back(3'(m_words.size()));
            qc1.push_back(3'(m_words.size()));
            m_words.delete();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic drive_beat(input logic [63:0] d, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready0 && guard < 50) begin
            @(negedge clk);
            guard++;
            stalls++;
        end
        if (!in_ready0) check("beat_stall", in_ready0, 1);
        model_accept(d, last);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
    endtask

    always @(negedge clk) begin
        if (out_valid0 && out_ready) begin
            hs_cyc.push_back(cyc);
            if (q0.size() == 0) check("unexpected_out0", out_valid0, 0);
            else begin
                check("data_msb", out_data0, q0.pop_front());
                check("count_msb", out_count0, qc0.pop_front());
            end
        end
        if (out_valid1 && out_ready) begin
            if (q1.size() == 0) check("unexpected_out1", out_valid1, 0);
            else begin
                check("data_lsb", out_data1, q1.pop_front());
                check("count_lsb", out_count1, qc1.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", out_valid0, 0);
        check("rst_data", out_data0, 0);
        check("rst_count", out_count0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready0, 1);

        // 1: four beats, one-cycle latency
        out_ready = 1'b1;
        drive_beat(64'd1, 1'b0);
        drive_beat(64'd2, 1'b0);
        drive_beat(64'd3, 1'b0);
        check("t1_early_valid", out_valid0, 0);
        drive_beat(64'd4, 1'b0);
        check("t1_latency0", out_valid0, 1);
        check("t1_latency1", out_valid1, 1);
        drain();

        // 2: eight back-to-back beats, no stalls, packets 4 cycles apart
        hs_cyc.delete();
        s0 = stalls;
        for (int i = 0; i < 8; i++) drive_beat(64'(32'h20 + i), 1'b0);
        check("t2_no_stall", stalls - s0, 0);
        drain();
        check("t2_hs_count", hs_cyc.size(), 2);
        if (hs_cyc.size() >= 2) check("t2_spacing", hs_cyc[1] - hs_cyc[0], 4);

        // 3: backpressure, second packet goes pending
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive_beat(64'(32'hA0 + i), 1'b0);
        check("t3_first_valid", out_valid0, 1);
        for (int i = 4; i < 8; i++) drive_beat(64'(32'hA0 + i), 1'b0);
        check("t3_pend_ready", in_ready0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("t3_pend_hold_ready", in_ready0, 0);
        check("t3_pend_hold_valid", out_valid0, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_refill_ready", in_ready0, 1);
        check("t3_refill_valid", out_valid0, 1);
        drain();

        // 4: early termination with zero padding
        drive_beat(64'd5, 1'b0);
        drive_beat(64'd6, 1'b1);
        drive_beat(64'd7, 1'b1);
        drain();

        // 5: clear discards a partial packet and blocks input
        drive_beat(64'd7, 1'b0);
        drive_beat(64'd8, 1'b0);
        in_valid = 1'b1;
        in_data  = 64'd99;
        clr      = 1'b1;
        @(negedge clk);
        check("t5_clr_ready", in_ready0, 0);
        @(posedge clk); #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        m_words.delete();
        for (int i = 9; i <= 12; i++) drive_beat(64'(i), 1'b0);
        drain();

        // 6: asynchronous reset while pending
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive_beat(64'(32'h60 + i), 1'b0);
        check("t6_pend", in_ready0, 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid0", out_valid0, 0);
        check("t6_async_valid1", out_valid1, 0);
        check("t6_async_count", out_count0, 0);
        q0.delete(); q1.delete(); qc0.delete(); qc1.delete(); m_words.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_in_ready", in_ready0, 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) drive_beat(64'(32'h70 + i), 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
